dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory request interface; sits between the core's MEM stage (initiator) and the word-indexed RAM port of the RAM helper.
- Accepts one load/store request at a time over a valid/ready handshake.
- Performs sized, aligned RAM access: stores use byte masks; loads are extracted and sign/zero extended.
- Returns a response over a valid/ready handshake; misaligned or out-of-range requests get an error response with no RAM access.

---
 rtl/dmem_responder.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data-memory request
// interface. It takes one load/store at a time and performs a sized, aligned
// access on a word-indexed 64-bit RAM port. Store data is lane-shifted and
// byte-masked. Load data is extracted and then sign- or zero-extended.
// Misaligned or out-of-range requests get an error response and do not touch
// the RAM.
// Optional feature: define DMEM_RESPONDER_PERF_EN to add 32-bit performance
// counters (perf_loads, perf_stores, perf_errs, perf_stall_cycles).
`timescale 1ns/1ps
module dmem_responder #(
  parameter logic [63:0] MEM_BASE  = 64'h8000_0000,
  parameter int unsigned MEM_WORDS = 32'd65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_en,
  output logic        ram_wen,
  output logic [63:0] ram_idx,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask,
  input  logic [63:0] ram_rdata
`ifdef DMEM_RESPONDER_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_errs,
  output logic [31:0] perf_stall_cycles
`endif
);

  // Size of the RAM window in bytes. The upper bound is computed as an offset
  // from MEM_BASE so that MEM_BASE + size never overflows.
  localparam logic [63:0] MEM_BYTES = {29'd0, MEM_WORDS, 3'b000};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;

  // Request attributes still needed after the handshake
  logic        wen_r;
  logic        signed_r;
  logic [1:0]  size_r;
  logic [2:0]  off_r;

  logic        req_fire_s;
  logic        in_range_s;
  logic        bad_s;

  // Registered outputs and their next values
  logic        req_ready_r,  req_ready_nxt_s;
  logic        resp_valid_r, resp_valid_nxt_s;
  logic [63:0] resp_rdata_r, resp_rdata_nxt_s;
  logic        resp_err_r,   resp_err_nxt_s;
  logic        ram_en_r,     ram_en_nxt_s;
  logic        ram_wen_r,    ram_wen_nxt_s;
  logic [63:0] ram_idx_r,    ram_idx_nxt_s;
  logic [63:0] ram_wdata_r,  ram_wdata_nxt_s;
  logic [63:0] ram_wmask_r,  ram_wmask_nxt_s;

  // Byte-lane enables for an access of 2^size bytes starting at lane 0
  function automatic logic [7:0] size_lanes(input logic [1:0] size);
    logic [7:0] lanes;
    case (size)
      2'd0:    lanes = 8'h01;
      2'd1:    lanes = 8'h03;
      2'd2:    lanes = 8'h0F;
      2'd3:    lanes = 8'hFF;
      default: lanes = 8'h00;
    endcase
    return lanes;
  endfunction

  // Bit mask covering the enabled byte lanes at the given byte offset
  function automatic logic [63:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0]  lanes;
    logic [63:0] mask;
    lanes = size_lanes(size) << off;
    mask  = 64'd0;
    for (int i = 0; i < 8; i++) begin
      mask[8*i +: 8] = {8{lanes[i]}};
    end
    return mask;
  endfunction

  // Natural alignment check: low address bits must be zero for the size
  function automatic logic is_misaligned(input logic [2:0] low, input logic [1:0] size);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = low[0];
      2'd2:    mis = |low[1:0];
      2'd3:    mis = |low[2:0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Pull the addressed bytes out of a RAM word and extend them to 64 bits
  function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [2:0] off,
                                              input logic [1:0] size, input logic sgn);
    logic [63:0] sh;
    logic [63:0] ext;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    ext = sgn ? {{56{sh[7]}},  sh[7:0]}  : {56'd0, sh[7:0]};
      2'd1:    ext = sgn ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
      2'd2:    ext = sgn ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
      2'd3:    ext = sh;
      default: ext = sh;
    endcase
    return ext;
  endfunction

  assign req_fire_s = req_valid && (state_r == IDLE);
  assign in_range_s = (req_addr >= MEM_BASE) && ((req_addr - MEM_BASE) < MEM_BYTES);
  assign bad_s      = is_misaligned(req_addr[2:0], req_size) || !in_range_s;

  // State register: advance the request/response FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: accept in IDLE, one RAM cycle, optional capture, hold response
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (bad_s) begin
            next_state_s = RESP;
          end else begin
            next_state_s = ACCESS;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        if (wen_r) begin
          next_state_s = RESP;
        end else begin
          next_state_s = CAPTURE;
        end
      end
      CAPTURE: next_state_s = RESP;
      RESP: begin
        if (resp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, decoded from the next state
  always_comb begin
    req_ready_nxt_s  = (next_state_s == IDLE);
    resp_valid_nxt_s = (next_state_s == RESP);
    ram_en_nxt_s     = (next_state_s == ACCESS);
    ram_wen_nxt_s    = (next_state_s == ACCESS) && req_wen;
    resp_rdata_nxt_s = resp_rdata_r;
    resp_err_nxt_s   = resp_err_r;
    ram_idx_nxt_s    = ram_idx_r;
    ram_wdata_nxt_s  = ram_wdata_r;
    ram_wmask_nxt_s  = ram_wmask_r;
    case (state_r)
      IDLE: begin
        if (req_fire_s) begin
          resp_rdata_nxt_s = 64'd0;
          resp_err_nxt_s   = bad_s;
          if (!bad_s) begin
            ram_idx_nxt_s = (req_addr - MEM_BASE) >> 3;
            if (req_wen) begin
              ram_wdata_nxt_s = req_wdata << {req_addr[2:0], 3'b000};
              ram_wmask_nxt_s = lane_mask(req_size, req_addr[2:0]);
            end else begin
              ram_wdata_nxt_s = ram_wdata_r;
              ram_wmask_nxt_s = ram_wmask_r;
            end
          end else begin
            ram_idx_nxt_s = ram_idx_r;
          end
        end else begin
          resp_rdata_nxt_s = resp_rdata_r;
          resp_err_nxt_s   = resp_err_r;
        end
      end
      CAPTURE: resp_rdata_nxt_s = load_extend(ram_rdata, off_r, size_r, signed_r);
      default: resp_rdata_nxt_s = resp_rdata_r;
    endcase
  end

  // Output registers: every interface output comes straight from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 64'd0;
      resp_err_r   <= 1'b0;
      ram_en_r     <= 1'b0;
      ram_wen_r    <= 1'b0;
      ram_idx_r    <= 64'd0;
      ram_wdata_r  <= 64'd0;
      ram_wmask_r  <= 64'd0;
    end else begin
      req_ready_r  <= req_ready_nxt_s;
      resp_valid_r <= resp_valid_nxt_s;
      resp_rdata_r <= resp_rdata_nxt_s;
      resp_err_r   <= resp_err_nxt_s;
      ram_en_r     <= ram_en_nxt_s;
      ram_wen_r    <= ram_wen_nxt_s;
      ram_idx_r    <= ram_idx_nxt_s;
      ram_wdata_r  <= ram_wdata_nxt_s;
      ram_wmask_r  <= ram_wmask_nxt_s;
    end
  end

  // Request capture: latch the attributes that the later states still need
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_r    <= 1'b0;
      signed_r <= 1'b0;
      size_r   <= 2'd0;
      off_r    <= 3'd0;
    end else if (req_fire_s) begin
      wen_r    <= req_wen;
      signed_r <= req_signed;
      size_r   <= req_size;
      off_r    <= req_addr[2:0];
    end else begin
      wen_r    <= wen_r;
      signed_r <= signed_r;
      size_r   <= size_r;
      off_r    <= off_r;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign ram_en     = ram_en_r;
  assign ram_wen    = ram_wen_r;
  assign ram_idx    = ram_idx_r;
  assign ram_wdata  = ram_wdata_r;
  assign ram_wmask  = ram_wmask_r;

`ifdef DMEM_RESPONDER_PERF_EN
  logic [31:0] perf_loads_r;
  logic [31:0] perf_stores_r;
  logic [31:0] perf_errs_r;
  logic [31:0] perf_stall_r;

  // Performance counters: completed responses by type, plus back-pressure cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads_r  <= 32'd0;
      perf_stores_r <= 32'd0;
      perf_errs_r   <= 32'd0;
      perf_stall_r  <= 32'd0;
    end else begin
      if (resp_valid_r && resp_ready) begin
        if (resp_err_r) begin
          perf_errs_r <= perf_errs_r + 32'd1;
        end else if (wen_r) begin
          perf_stores_r <= perf_stores_r + 32'd1;
        end else begin
          perf_loads_r <= perf_loads_r + 32'd1;
        end
      end else begin
        perf_loads_r <= perf_loads_r;
      end
      if (resp_valid_r && !resp_ready) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end else begin
        perf_stall_r <= perf_stall_r;
      end
    end
  end

  assign perf_loads        = perf_loads_r;
  assign perf_stores       = perf_stores_r;
  assign perf_errs         = perf_errs_r;
  assign perf_stall_cycles = perf_stall_r;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. The bench acts as the RAM helper and keeps an
// independent byte-level memory model. It checks the directed scenarios and
// then randomized traffic for latency, RAM strobes, and response values.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam logic [63:0] BASE     = 64'h8000_0000;
  localparam logic [63:0] LIMIT    = 64'h8008_0000;
  localparam logic [63:0] LAST_OFF = 64'h0007_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        ram_en;
  logic        ram_wen;
  logic [63:0] ram_idx;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;
  logic [63:0] ram_rdata = 64'd0;
`ifdef DMEM_RESPONDER_PERF_EN
  logic [31:0] perf_loads, perf_stores, perf_errs, perf_stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_loads = 0, cnt_stores = 0, cnt_errs = 0, cnt_stalls = 0;
  bit ram_oob = 1'b0;

  // RAM helper storage: words 0..15 in slots 0..15, last word (65535) in slot 16
  logic [63:0] ram_mem [0:16];
  // Reference model: bytes 0..127 and the 8 bytes of the last RAM word
  logic [7:0]  ref_bytes [0:135];

  dmem_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_idx(ram_idx), .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
`ifdef DMEM_RESPONDER_PERF_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_errs(perf_errs),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic int ram_slot(input logic [63:0] idx);
    if (idx < 64'd16) return int'(idx);
    else if (idx == 64'd65535) return 16;
    else return -1;
  endfunction

  // RAM helper: masked writes, read data valid the cycle after the strobe
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_slot(ram_idx) < 0) begin
        ram_oob <= 1'b1;
      end else if (ram_wen) begin
        ram_mem[ram_slot(ram_idx)] <= (ram_mem[ram_slot(ram_idx)] & ~ram_wmask) | (ram_wdata & ram_wmask);
      end else begin
        ram_rdata <= ram_mem[ram_slot(ram_idx)];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ref_slot(input logic [63:0] off);
    if (off < 64'd128) return int'(off);
    else return 128 + int'(off - LAST_OFF);
  endfunction

  function automatic bit ref_bad(input logic [63:0] a, input logic [1:0] sz);
    logic [63:0] nb;
    nb = 64'd1 << sz;
    return ((a % nb) != 64'd0) || (a < BASE) || (a >= LIMIT);
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz, input bit sgn);
    logic [63:0] v;
    int n, o;
    v = 64'd0;
    n = 1 << sz;
    o = ref_slot(a - BASE);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[o + i];
    if (sgn && n < 8 && v[8*n-1]) begin
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d);
    int o;
    o = ref_slot(a - BASE);
    for (int i = 0; i < (1 << sz); i++) ref_bytes[o + i] = d[8*i +: 8];
  endtask

  // One complete transaction with timing, strobe and response checks
  task automatic do_req(input bit wen, input logic [63:0] addr, input logic [1:0] sz, input bit sgn,
                        input logic [63:0] wdata, input int stall,
                        output logic [63:0] got_rdata, output logic [63:0] got_wdata,
                        output logic [63:0] got_wmask);
    bit          bad, seen;
    logic [63:0] exp_rd, exp_mask;
    int          exp_lat, lat, en_cnt;
    bad    = ref_bad(addr, sz);
    exp_rd = (!bad && !wen) ? ref_load(addr, sz, sgn) : 64'd0;
    exp_lat = bad ? 1 : (wen ? 2 : 3);
    exp_mask = 64'd0;
    for (int i = 0; i < (1 << sz); i++) exp_mask[8*(int'(addr[2:0]) + i) +: 8] = 8'hFF;
    got_wdata = 64'd0;
    got_wmask = 64'd0;
    @(negedge clk);
    check_eq("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = sz;
    req_signed = sgn; req_wdata = wdata;
    @(posedge clk); #1;
    // Garbage on the request bus while busy must be ignored
    req_valid = 1'($urandom_range(0, 1)); req_wen = 1'($urandom_range(0, 1));
    req_addr = {$urandom, $urandom}; req_size = 2'($urandom_range(0, 3));
    req_wdata = {$urandom, $urandom};
    if (!bad && wen) ref_store(addr, sz, wdata);
    if (bad) cnt_errs++; else if (wen) cnt_stores++; else cnt_loads++;
    cnt_stalls += stall;
    seen = 1'b0; lat = 0; en_cnt = 0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      @(negedge clk);
      if (ram_en) begin
        en_cnt++;
        check_eq("ram_wen", ram_wen, wen);
        check_eq("ram_idx", ram_idx, (addr - BASE) >> 3);
        if (wen) begin
          check_eq("ram_wdata", ram_wdata, wdata << (8 * int'(addr[2:0])));
          check_eq("ram_wmask", ram_wmask, exp_mask);
          got_wdata = ram_wdata;
          got_wmask = ram_wmask;
        end
      end
      if (resp_valid) begin
        seen = 1'b1;
        lat = c;
      end
    end
    check_eq("resp_latency", lat, exp_lat);
    check_eq("resp_err", resp_err, bad);
    check_eq("resp_rdata", resp_rdata, exp_rd);
    check_eq("req_ready_busy", req_ready, 1'b0);
    got_rdata = resp_rdata;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq("stall_valid", resp_valid, 1'b1);
      check_eq("stall_rdata", resp_rdata, exp_rd);
      check_eq("stall_err", resp_err, bad);
      check_eq("stall_ready", req_ready, 1'b0);
      check_eq("stall_ram_en", ram_en, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid = 1'b0;
    check_eq("post_resp_valid", resp_valid, 1'b0);
    check_eq("post_req_ready", req_ready, 1'b1);
    check_eq("ram_en_count", en_cnt, bad ? 0 : 1);
  endtask

  // Reset while a load sits in the capture cycle
  task automatic mid_reset();
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 64'h10; req_size = 2'd3; req_signed = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mrst_resp_valid", resp_valid, 1'b0);
    check_eq("mrst_req_ready", req_ready, 1'b1);
    check_eq("mrst_ram_en", ram_en, 1'b0);
    check_eq("mrst_rdata", resp_rdata, 64'd0);
    check_eq("mrst_err", resp_err, 1'b0);
    check_eq("mrst_ram_idx", ram_idx, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt_loads = 0; cnt_stores = 0; cnt_errs = 0; cnt_stalls = 0;
  endtask

  initial begin
    logic [63:0] gr, gw, gm, a, w;
    logic [1:0]  sz;
    for (int k = 0; k < 17; k++) begin
      w = {$urandom, $urandom};
      ram_mem[k] = w;
      for (int b = 0; b < 8; b++) ref_bytes[8*k + b] = w[8*b +: 8];
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1'b1);
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_rdata", resp_rdata, 64'd0);
    check_eq("rst_err", resp_err, 1'b0);
    check_eq("rst_ram_en", ram_en, 1'b0);
    check_eq("rst_ram_wen", ram_wen, 1'b0);
    check_eq("rst_ram_idx", ram_idx, 64'd0);
    check_eq("rst_ram_wdata", ram_wdata, 64'd0);
    check_eq("rst_ram_wmask", ram_wmask, 64'd0);
    rst = 1'b0;

    do_req(1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 0, gr, gw, gm);
    check_eq("tp_sd_mask", gm, 64'hFFFF_FFFF_FFFF_FFFF);
    do_req(1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'h0000_0000_8000_0000, 0, gr, gw, gm);
    do_req(1'b0, 64'h8000_0013, 2'd0, 1'b1, 64'd0, 0, gr, gw, gm);
    check_eq("tp_lb_signed", gr, 64'hFFFF_FFFF_FFFF_FF80);
    do_req(1'b0, 64'h8000_0013, 2'd0, 1'b0, 64'd0, 1, gr, gw, gm);
    check_eq("tp_lb_unsigned", gr, 64'h0000_0000_0000_0080);
    do_req(1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'hBEEF_0000_0000_0000, 0, gr, gw, gm);
    do_req(1'b0, 64'h8000_0016, 2'd1, 1'b0, 64'd0, 0, gr, gw, gm);
    check_eq("tp_lh_unsigned", gr, 64'h0000_0000_0000_BEEF);
    do_req(1'b0, 64'h8000_0016, 2'd1, 1'b1, 64'd0, 0, gr, gw, gm);
    check_eq("tp_lh_signed", gr, 64'hFFFF_FFFF_FFFF_BEEF);
    do_req(1'b1, 64'h8000_0006, 2'd1, 1'b0, 64'h0000_0000_0000_ABCD, 0, gr, gw, gm);
    check_eq("tp_sh_wdata", gw, 64'hABCD_0000_0000_0000);
    check_eq("tp_sh_wmask", gm, 64'hFFFF_0000_0000_0000);
    do_req(1'b0, 64'h8000_0002, 2'd2, 1'b0, 64'd0, 0, gr, gw, gm);
    do_req(1'b1, 64'h7FFF_FFF8, 2'd3, 1'b0, 64'h1234, 0, gr, gw, gm);
    do_req(1'b0, 64'h7FFF_FFF8, 2'd0, 1'b0, 64'd0, 0, gr, gw, gm);
    do_req(1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'd0, 5, gr, gw, gm);
    check_eq("tp_stall_load", gr, 64'hBEEF_0000_0000_0000);
    mid_reset();

    for (int k = 0; k < 80; k++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       a = BASE - 64'd8;
        1:       a = BASE + LAST_OFF + 64'($urandom_range(0, 7));
        2:       a = LIMIT;
        3:       a = 64'hFFFF_FFFF_8000_0010;
        default: a = BASE + 64'($urandom_range(0, 127));
      endcase
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      do_req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), {$urandom, $urandom},
             int'($urandom_range(0, 3)), gr, gw, gm);
    end

`ifdef DMEM_RESPONDER_PERF_EN
    check_eq("perf_loads", perf_loads, cnt_loads);
    check_eq("perf_stores", perf_stores, cnt_stores);
    check_eq("perf_errs", perf_errs, cnt_errs);
    check_eq("perf_stalls", perf_stall_cycles, cnt_stalls);
`endif
    check_eq("ram_idx_in_model", ram_oob, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
